// File: rtl/stream_framer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_framer_pkg : shared state / word-class types for the stream framer
// Revision: 1.0
// ---------------------------------------------------------------------------
package stream_framer_pkg;

  localparam int LEN_WIDTH = 16;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    HDR_BX0 = 2'd2,
    ERR     = 2'd3
  } word_class_t;

endpackage
`default_nettype wire

// File: rtl/stream_word_classifier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_word_classifier : combinational idle / header match of one word
// Revision: 1.0
// ---------------------------------------------------------------------------
module stream_word_classifier
  import stream_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] idle_word,
  input  logic [DATA_WIDTH-1:0] idle_word_bx0,
  input  logic [DATA_WIDTH-1:0] header_mask,
  input  logic [DATA_WIDTH-1:0] header,
  input  logic [DATA_WIDTH-1:0] header_bx0,
  output word_class_t           word_class
);

  // Idle beats a header match; the BX0 header beats the plain one.
  always_comb begin
    word_class = ERR;
    if (data == idle_word || data == idle_word_bx0)
      word_class = IDLE;
    else if ((data & header_mask) == (header_bx0 & header_mask))
      word_class = HDR_BX0;
    else if ((data & header_mask) == (header & header_mask))
      word_class = HDR;
  end

endmodule
`default_nettype wire

// File: rtl/stream_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_framer : header hunt, fixed-length packet forwarding, status counters
// Revision: 1.0
// ---------------------------------------------------------------------------
module stream_framer
  import stream_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  packet_words,
  input  logic [DATA_WIDTH-1:0] idle_word,
  input  logic [DATA_WIDTH-1:0] idle_word_BX0,
  input  logic [DATA_WIDTH-1:0] header_mask,
  input  logic [DATA_WIDTH-1:0] header,
  input  logic [DATA_WIDTH-1:0] header_BX0,
  input  logic                  fc_linkReset,
  input  logic                  counter_clear,
  output logic [CNT_WIDTH-1:0]  packet_count,
  output logic [CNT_WIDTH-1:0]  idle_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  trunc_count
);

  state_t                r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_remaining, w_remaining_nxt;
  logic [LEN_WIDTH-1:0]  w_len;
  word_class_t           w_class;
  logic                  w_accept;
  logic                  w_fwd, w_last, w_user;
  logic                  w_inc_pkt, w_inc_idle, w_inc_err, w_inc_trunc;

  stream_word_classifier #(.DATA_WIDTH(DATA_WIDTH)) u_classifier (
    .data          (s_tdata),
    .idle_word     (idle_word),
    .idle_word_bx0 (idle_word_BX0),
    .header_mask   (header_mask),
    .header        (header),
    .header_bx0    (header_BX0),
    .word_class    (w_class)
  );

  assign s_tready = resetn && (!m_tvalid || m_tready);
  assign w_accept = s_tvalid && s_tready;
  assign w_len    = (packet_words == '0) ? LEN_WIDTH'(1) : packet_words;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= HUNT;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_fwd           = 1'b0;
    w_last          = 1'b0;
    w_user          = 1'b0;
    w_inc_pkt       = 1'b0;
    w_inc_idle      = 1'b0;
    w_inc_err       = 1'b0;
    w_inc_trunc     = 1'b0;
    // Link reset and disable both abandon any open packet; the beat is dropped.
    if (fc_linkReset || !enable) begin
      w_state_nxt     = HUNT;
      w_remaining_nxt = '0;
      w_inc_trunc     = (r_state == PAYLOAD);
    end else if (w_accept) begin
      case (r_state)
        HUNT: begin
          case (w_class)
            IDLE: w_inc_idle = 1'b1;
            ERR:  w_inc_err  = 1'b1;
            default: begin
              w_fwd  = 1'b1;
              w_user = (w_class == HDR_BX0);
              if (w_len == LEN_WIDTH'(1)) begin
                w_last    = 1'b1;
                w_inc_pkt = 1'b1;
              end else begin
                w_state_nxt     = PAYLOAD;
                w_remaining_nxt = w_len - LEN_WIDTH'(1);
              end
            end
          endcase
        end
        PAYLOAD: begin
          w_fwd           = 1'b1;
          w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
          if (r_remaining == LEN_WIDTH'(1)) begin
            w_last      = 1'b1;
            w_inc_pkt   = 1'b1;
            w_state_nxt = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (w_fwd) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tlast  <= w_last;
      m_tuser  <= w_user;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      packet_count <= '0;
      idle_count   <= '0;
      error_count  <= '0;
      trunc_count  <= '0;
    end else if (counter_clear) begin
      packet_count <= '0;
      idle_count   <= '0;
      error_count  <= '0;
      trunc_count  <= '0;
    end else begin
      if (w_inc_pkt)   packet_count <= packet_count + CNT_WIDTH'(1);
      if (w_inc_idle)  idle_count   <= idle_count   + CNT_WIDTH'(1);
      if (w_inc_err)   error_count  <= error_count  + CNT_WIDTH'(1);
      if (w_inc_trunc) trunc_count  <= trunc_count  + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire
